// File: rtl/layer_sequencer.sv
// Sequences one fully-connected layer. It latches the input vector, pulses start, gathers each neuron's result and presents the vector downstream.
// out_valid follows start by NUM_INPUTS+3 cycles for nominal neurons; in HOLD, in_ready follows out_ready so vectors chain with no idle cycle.
module layer_sequencer #(
  parameter int NUM_INPUTS     = 16,
  parameter int NUM_NEURONS    = 8,
  parameter int TIMEOUT_CYCLES = NUM_INPUTS + 4,
  parameter int INTEGER_WIDTH  = 8,
  parameter int FRACTION_WIDTH = 8
) (
  input  logic                                                 clock,
  input  logic                                                 reset,
  input  logic                                                 in_valid,
  output logic                                                 in_ready,
  input  logic [NUM_INPUTS*(INTEGER_WIDTH+FRACTION_WIDTH)-1:0]  in_data,
  output logic [NUM_INPUTS*(INTEGER_WIDTH+FRACTION_WIDTH)-1:0]  neuron_inputs,
  output logic                                                 neuron_start,
  input  logic [NUM_NEURONS-1:0]                               neuron_done,
  input  logic [NUM_NEURONS*(INTEGER_WIDTH+FRACTION_WIDTH)-1:0] neuron_outputs,
  output logic                                                 out_valid,
  input  logic                                                 out_ready,
  output logic [NUM_NEURONS*(INTEGER_WIDTH+FRACTION_WIDTH)-1:0] out_data,
  output logic                                                 busy,
  output logic                                                 timeout_error,
  output logic [15:0]                                          vector_count
);
  localparam int W  = INTEGER_WIDTH + FRACTION_WIDTH;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;

  state_t                 state;
  logic [NUM_NEURONS-1:0] done_mask;
  logic [CW-1:0]          wait_count;
  logic                   accept;
  logic                   all_done;

  assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept   = in_valid && in_ready;
  // Pulses landing this cycle count towards completion.
  assign all_done = &(done_mask | neuron_done);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      done_mask     <= '0;
      wait_count    <= '0;
      neuron_inputs <= '0;
      neuron_start  <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      busy          <= 1'b0;
      timeout_error <= 1'b0;
      vector_count  <= '0;
    end else begin
      neuron_start <= 1'b0;
      if (accept) neuron_inputs <= in_data;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state        <= START;
            neuron_start <= 1'b1;
            busy         <= 1'b1;
          end
        end
        START: begin
          done_mask  <= '0;
          out_data   <= '0;
          wait_count <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          wait_count <= wait_count + CW'(1);
          for (int i = 0; i < NUM_NEURONS; i++) begin
            if (neuron_done[i] && !done_mask[i]) begin
              out_data[i*W +: W] <= neuron_outputs[i*W +: W];
              done_mask[i]       <= 1'b1;
            end
          end
          if (all_done) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end else if (wait_count == CW'(TIMEOUT_CYCLES - 1)) begin
            timeout_error <= 1'b1;
            state         <= HOLD;
            out_valid     <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            vector_count <= vector_count + 16'd1;
            out_valid    <= 1'b0;
            if (in_valid) begin
              state        <= START;
              neuron_start <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
